id_ex_pipe_reg: RTL and testbench

- Parametrised ID→EX pipeline register for the pipelined MIPS core.
- Carries operand data, the extended immediate, the instruction word, a packed control bus and a valid bit.
- Supports stall (hold), flush (bubble insertion) and write-back refresh of held operands during a stall.
- Keeps saturating stall and bubble counters for the hazard unit and debug.

---
 rtl/id_ex_pipe_reg.sv | 87 ++++++++
 tb/tb_id_ex_pipe_reg.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_pipe_reg.sv
// ID->EX pipeline register for the pipelined MIPS core.
// Supports stall, flush, write-back refresh of held operands, and saturating stall/bubble counters.
module id_ex_pipe_reg #(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned INSTR_W = 32,
  parameter int unsigned CTRL_W  = 8,
  parameter int unsigned REG_AW  = 5,
  parameter int unsigned CNT_W   = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               stall,
  input  logic               flush,
  input  logic               valid_ID,
  input  logic [DATA_W-1:0]  rsdata_ID,
  input  logic [DATA_W-1:0]  rtdata_ID,
  input  logic [DATA_W-1:0]  extendedimm_ID,
  input  logic [INSTR_W-1:0] Instr_ID,
  input  logic [CTRL_W-1:0]  ctrl_ID,
  input  logic               RegDst_ID,
  input  logic               wb_we,
  input  logic [REG_AW-1:0]  wb_addr,
  input  logic [DATA_W-1:0]  wb_data,
  output logic               valid_Ex,
  output logic [DATA_W-1:0]  rsdata_Ex,
  output logic [DATA_W-1:0]  rtdata_Ex,
  output logic [DATA_W-1:0]  extendedimm_Ex,
  output logic [INSTR_W-1:0] Instr_Ex,
  output logic [CTRL_W-1:0]  ctrl_Ex,
  output logic               RegDst_Ex,
  output logic [CNT_W-1:0]   stall_cnt,
  output logic [CNT_W-1:0]   bubble_cnt
);

  logic [REG_AW-1:0] rs_ex;
  logic [REG_AW-1:0] rt_ex;
  logic              refresh_rs;
  logic              refresh_rt;
  logic              stall_sat;
  logic              bubble_sat;

  // A held instruction must see results retired by WB while it waits in EX.
  always_comb begin
    rs_ex      = REG_AW'(Instr_Ex[25:21]);
    rt_ex      = REG_AW'(Instr_Ex[20:16]);
    refresh_rs = valid_Ex && wb_we && (wb_addr != '0) && (wb_addr == rs_ex);
    refresh_rt = valid_Ex && wb_we && (wb_addr != '0) && (wb_addr == rt_ex);
    stall_sat  = &stall_cnt;
    bubble_sat = &bubble_cnt;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_Ex       <= 1'b0;
      rsdata_Ex      <= '0;
      rtdata_Ex      <= '0;
      extendedimm_Ex <= '0;
      Instr_Ex       <= '0;
      ctrl_Ex        <= '0;
      RegDst_Ex      <= 1'b0;
      stall_cnt      <= '0;
      bubble_cnt     <= '0;
    end else if (flush) begin
      valid_Ex       <= 1'b0;
      rsdata_Ex      <= '0;
      rtdata_Ex      <= '0;
      extendedimm_Ex <= '0;
      Instr_Ex       <= '0;
      ctrl_Ex        <= '0;
      RegDst_Ex      <= 1'b0;
      if (!bubble_sat) bubble_cnt <= bubble_cnt + 1'b1;
    end else if (stall) begin
      if (!stall_sat) stall_cnt <= stall_cnt + 1'b1;
      if (refresh_rs) rsdata_Ex <= wb_data;
      if (refresh_rt) rtdata_Ex <= wb_data;
    end else begin
      valid_Ex       <= valid_ID;
      rsdata_Ex      <= rsdata_ID;
      rtdata_Ex      <= rtdata_ID;
      extendedimm_Ex <= extendedimm_ID;
      Instr_Ex       <= Instr_ID;
      ctrl_Ex        <= ctrl_ID;
      RegDst_Ex      <= RegDst_ID;
    end
  end

endmodule

// File: tb/tb_id_ex_pipe_reg.sv
// Scoreboard bench for id_ex_pipe_reg: directed plan steps plus random traffic against a reference model.
// A second instance with 2-bit counters exercises saturation.
module tb_id_ex_pipe_reg;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, stall, flush, valid_ID, RegDst_ID, wb_we;
  logic [31:0] rsdata_ID, rtdata_ID, extendedimm_ID, Instr_ID, wb_data;
  logic [7:0]  ctrl_ID;
  logic [4:0]  wb_addr;

  logic        valid_Ex, RegDst_Ex;
  logic [31:0] rsdata_Ex, rtdata_Ex, extendedimm_Ex, Instr_Ex;
  logic [7:0]  ctrl_Ex;
  logic [15:0] stall_cnt, bubble_cnt;

  logic        s_valid_Ex, s_RegDst_Ex;
  logic [31:0] s_rsdata_Ex, s_rtdata_Ex, s_extendedimm_Ex, s_Instr_Ex;
  logic [7:0]  s_ctrl_Ex;
  logic [1:0]  s_stall_cnt, s_bubble_cnt;

  id_ex_pipe_reg #(.DATA_W(32), .INSTR_W(32), .CTRL_W(8), .REG_AW(5), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush), .valid_ID(valid_ID),
    .rsdata_ID(rsdata_ID), .rtdata_ID(rtdata_ID), .extendedimm_ID(extendedimm_ID),
    .Instr_ID(Instr_ID), .ctrl_ID(ctrl_ID), .RegDst_ID(RegDst_ID),
    .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data),
    .valid_Ex(valid_Ex), .rsdata_Ex(rsdata_Ex), .rtdata_Ex(rtdata_Ex),
    .extendedimm_Ex(extendedimm_Ex), .Instr_Ex(Instr_Ex), .ctrl_Ex(ctrl_Ex),
    .RegDst_Ex(RegDst_Ex), .stall_cnt(stall_cnt), .bubble_cnt(bubble_cnt)
  );

  id_ex_pipe_reg #(.DATA_W(32), .INSTR_W(32), .CTRL_W(8), .REG_AW(5), .CNT_W(2)) dut_small (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush), .valid_ID(valid_ID),
    .rsdata_ID(rsdata_ID), .rtdata_ID(rtdata_ID), .extendedimm_ID(extendedimm_ID),
    .Instr_ID(Instr_ID), .ctrl_ID(ctrl_ID), .RegDst_ID(RegDst_ID),
    .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data),
    .valid_Ex(s_valid_Ex), .rsdata_Ex(s_rsdata_Ex), .rtdata_Ex(s_rtdata_Ex),
    .extendedimm_Ex(s_extendedimm_Ex), .Instr_Ex(s_Instr_Ex), .ctrl_Ex(s_ctrl_Ex),
    .RegDst_Ex(s_RegDst_Ex), .stall_cnt(s_stall_cnt), .bubble_cnt(s_bubble_cnt)
  );

  typedef struct {
    bit          valid;
    bit [31:0]   rs, rt, imm, instr;
    bit [7:0]    ctrl;
    bit          regdst;
    int unsigned sc, bc, sc2, bc2;
  } exp_t;

  exp_t model;
  exp_t sb[$];
  int total = 0;
  int bad   = 0;

  function automatic int unsigned sat_inc(int unsigned v, int unsigned maxv);
    return (v >= maxv) ? maxv : v + 1;
  endfunction

  // Reference behaviour: what EX should hold after the coming edge, given current inputs.
  function automatic exp_t next_state(exp_t m);
    exp_t n = m;
    int unsigned rs_idx, rt_idx;
    if (reset) begin
      n = '{default: 0};
    end else if (flush) begin
      n.valid = 0; n.rs = 0; n.rt = 0; n.imm = 0; n.instr = 0; n.ctrl = 0; n.regdst = 0;
      n.bc  = sat_inc(m.bc, 65535);
      n.bc2 = sat_inc(m.bc2, 3);
    end else if (stall) begin
      n.sc  = sat_inc(m.sc, 65535);
      n.sc2 = sat_inc(m.sc2, 3);
      rs_idx = (m.instr >> 21) & 31;
      rt_idx = (m.instr >> 16) & 31;
      if (m.valid && wb_we && wb_addr != 0 && int'(wb_addr) == int'(rs_idx)) n.rs = wb_data;
      if (m.valid && wb_we && wb_addr != 0 && int'(wb_addr) == int'(rt_idx)) n.rt = wb_data;
    end else begin
      n.valid = valid_ID; n.rs = rsdata_ID; n.rt = rtdata_ID; n.imm = extendedimm_ID;
      n.instr = Instr_ID; n.ctrl = ctrl_ID; n.regdst = RegDst_ID;
    end
    return n;
  endfunction

  task automatic step(input bit r, input bit f, input bit s);
    reset = r; flush = f; stall = s;
    model = next_state(model);
    sb.push_back(model);
    @(negedge clk);
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h t=%0t", name, got, want, $time);
    end
  endtask

  // Monitor: EX presents a new state after every edge; pop and compare.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        total++;
        if (valid_Ex !== e.valid || rsdata_Ex !== e.rs || rtdata_Ex !== e.rt ||
            extendedimm_Ex !== e.imm || Instr_Ex !== e.instr || ctrl_Ex !== e.ctrl ||
            RegDst_Ex !== e.regdst) begin
          bad++;
          $display("FAIL ex_fields t=%0t got v=%b rs=%h rt=%h imm=%h in=%h c=%h rd=%b expected v=%b rs=%h rt=%h imm=%h in=%h c=%h rd=%b",
                   $time, valid_Ex, rsdata_Ex, rtdata_Ex, extendedimm_Ex, Instr_Ex, ctrl_Ex, RegDst_Ex,
                   e.valid, e.rs, e.rt, e.imm, e.instr, e.ctrl, e.regdst);
        end
        total++;
        if (int'(stall_cnt) != int'(e.sc) || int'(bubble_cnt) != int'(e.bc) ||
            int'(s_stall_cnt) != int'(e.sc2) || int'(s_bubble_cnt) != int'(e.bc2)) begin
          bad++;
          $display("FAIL counters t=%0t got sc=%0d bc=%0d sc2=%0d bc2=%0d expected sc=%0d bc=%0d sc2=%0d bc2=%0d",
                   $time, stall_cnt, bubble_cnt, s_stall_cnt, s_bubble_cnt, e.sc, e.bc, e.sc2, e.bc2);
        end
      end
    end
  end

  task automatic set_id(input bit v, input logic [31:0] ins, input logic [31:0] rsd,
                        input logic [31:0] rtd, input logic [7:0] c);
    valid_ID = v; Instr_ID = ins; rsdata_ID = rsd; rtdata_ID = rtd; ctrl_ID = c;
    extendedimm_ID = 32'h0000_0004; RegDst_ID = 1'b1;
  endtask

  initial begin
    model = '{default: 0};
    wb_we = 1'b0; wb_addr = '0; wb_data = '0;
    set_id(1'b1, 32'hFFFF_FFFF, 32'h1111_1111, 32'h2222_2222, 8'hFF);

    // Reset with nonzero inputs
    step(1, 0, 0); step(1, 0, 0);
    check("rst_valid", {31'd0, valid_Ex}, 32'd0);
    check("rst_instr", Instr_Ex, 32'd0);
    check("rst_stall_cnt", {16'd0, stall_cnt}, 32'd0);

    // Load
    set_id(1'b1, 32'h012A_4020, 32'd5, 32'd7, 8'hA5);
    step(0, 0, 0);
    check("load_instr", Instr_Ex, 32'h012A_4020);
    check("load_rs", rsdata_Ex, 32'd5);
    check("load_rt", rtdata_Ex, 32'd7);
    check("load_ctrl", {24'd0, ctrl_Ex}, 32'h0000_00A5);
    check("load_cnt", {16'd0, stall_cnt}, 32'd0);

    // Stall hold for 3 cycles while ID changes
    set_id(1'b1, 32'h8D09_0004, 32'd100, 32'd200, 8'h3C);
    step(0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      set_id(1'b1, 32'hAC00_0000 + 32'(i), 32'd300 + 32'(i), 32'd400, 8'h11);
      step(0, 0, 1);
    end
    check("stall_hold_instr", Instr_Ex, 32'h8D09_0004);
    check("stall_cnt3", {16'd0, stall_cnt}, 32'd3);
    step(0, 0, 0);
    check("stall_release", Instr_Ex, 32'hAC00_0002);

    // Flush wins over stall
    step(0, 1, 1);
    check("flush_valid", {31'd0, valid_Ex}, 32'd0);
    check("flush_instr", Instr_Ex, 32'd0);
    check("flush_bubble", {16'd0, bubble_cnt}, 32'd1);
    check("flush_stall_cnt", {16'd0, stall_cnt}, 32'd3);

    // WB refresh with rs == rt == 9
    set_id(1'b1, 32'h0129_5020, 32'd3, 32'd3, 8'h81);
    step(0, 0, 0);
    wb_we = 1'b1; wb_addr = 5'd9; wb_data = 32'h0000_DEAD;
    step(0, 0, 1);
    check("wb_rs", rsdata_Ex, 32'h0000_DEAD);
    check("wb_rt", rtdata_Ex, 32'h0000_DEAD);
    wb_addr = 5'd0; wb_data = 32'h0000_BEEF;
    step(0, 0, 1);
    check("wb_r0_rs", rsdata_Ex, 32'h0000_DEAD);
    wb_addr = 5'd9;
    set_id(1'b1, 32'h0129_5020, 32'd11, 32'd22, 8'h81);
    step(0, 0, 0);
    check("wb_nostall_rs", rsdata_Ex, 32'd11);
    check("wb_nostall_rt", rtdata_Ex, 32'd22);
    wb_we = 1'b0;

    // Saturation on the 2-bit instance
    step(1, 0, 0);
    for (int i = 0; i < 6; i++) begin
      step(0, 0, 1);
      check("sat_stall", {30'd0, s_stall_cnt}, (i < 2) ? 32'(i + 1) : 32'd3);
    end
    for (int i = 0; i < 5; i++) begin
      step(0, 1, 0);
      check("sat_bubble", {30'd0, s_bubble_cnt}, (i < 2) ? 32'(i + 1) : 32'd3);
    end

    // Reset mid-stall
    step(1, 0, 0);
    step(0, 0, 1); step(0, 0, 1);
    check("mid_stall_cnt", {16'd0, stall_cnt}, 32'd2);
    step(1, 0, 1);
    check("mid_rst_cnt", {16'd0, stall_cnt}, 32'd0);
    check("mid_rst_rs", rsdata_Ex, 32'd0);
    step(0, 0, 1);
    check("mid_rst_recount", {16'd0, stall_cnt}, 32'd1);

    // Random traffic
    for (int i = 0; i < 1500; i++) begin
      logic [31:0] ins;
      ins = $urandom;
      ins[25:21] = 5'($urandom_range(0, 3));
      ins[20:16] = 5'($urandom_range(0, 3));
      set_id(1'($urandom), ins, $urandom, $urandom, 8'($urandom));
      extendedimm_ID = $urandom;
      RegDst_ID = 1'($urandom);
      wb_we = 1'($urandom);
      wb_addr = 5'($urandom_range(0, 3));
      wb_data = $urandom;
      step($urandom_range(0, 99) < 2, $urandom_range(0, 99) < 10, $urandom_range(0, 99) < 35);
    end

    repeat (2) @(negedge clk);
    check("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
